// File: rtl/clc_bus_pkg.sv
// Shared types for the CPU/video RAM arbiter: FSM states, grant owners and
// the legal RAM read-latency range.
package clc_bus_pkg;

   typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} state_t;

   typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_VID} owner_t;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 3;

   // Wide enough to count 0 .. RD_LAT_MAX-1 cycles in WAIT
   typedef logic [$clog2(RD_LAT_MAX)-1:0] lat_cnt_t;

   // Forces an out-of-range latency parameter into the supported window
   function automatic int clamp_rd_latency(input int lat);
      if (lat < RD_LAT_MIN) return RD_LAT_MIN;
      if (lat > RD_LAT_MAX) return RD_LAT_MAX;
      return lat;
   endfunction

endpackage

// File: rtl/cpu_mem_arbiter_if.sv
// Bus bundle for the arbiter: CPU side, video DMA read port and RAM port.
// The slave modport is the arbiter's view, master is the surrounding system.
interface cpu_mem_arbiter_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
);
   logic [ADDR_W-1:0] addr;
   logic              rd_req;
   logic              wr_en;
   logic [DATA_W-1:0] wr_data;
   logic [DATA_W-1:0] rd_data;
   logic              ready;

   logic              vid_req;
   logic [ADDR_W-1:0] vid_addr;
   logic [DATA_W-1:0] vid_data;
   logic              vid_ack;

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_wr_en;
   logic [DATA_W-1:0] mem_wr_data;
   logic [DATA_W-1:0] mem_rd_data;

   modport slave (
      input  addr, rd_req, wr_en, wr_data, vid_req, vid_addr, mem_rd_data,
      output rd_data, ready, vid_data, vid_ack, mem_addr, mem_wr_en, mem_wr_data
   );

   modport master (
      output addr, rd_req, wr_en, wr_data, vid_req, vid_addr, mem_rd_data,
      input  rd_data, ready, vid_data, vid_ack, mem_addr, mem_wr_en, mem_wr_data
   );
endinterface

// File: rtl/cpu_req_capture.sv
// Absorbs the CPU's one-cycle rd_req/wr_en pulses into pending registers,
// holds the read result and generates the level-style ready.
module cpu_req_capture #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] addr,
   input  logic              rd_req,
   input  logic              wr_en,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              rd_done,     // pending read completes this edge
   input  logic              wr_grant,    // pending write issued this edge
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              rd_pend,
   output logic [ADDR_W-1:0] rd_addr,
   output logic              wr_pend,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data_q,
   output logic [DATA_W-1:0] rd_data,
   output logic              ready
);
   logic rd_take, wr_take, rd_pend_n, wr_pend_n;

   // Next pending state: a same-type pulse while still pending is dropped,
   // but one arriving on the retiring edge is accepted.
   always_comb begin
      // NOTE: every always_comb output gets a value before any branch, so no latch is inferred.
      rd_take   = rd_req & (~rd_pend | rd_done);
      wr_take   = wr_en  & (~wr_pend | wr_grant);
      rd_pend_n = (rd_pend & ~rd_done)  | rd_req;
      wr_pend_n = (wr_pend & ~wr_grant) | wr_en;
   end

   // Pending registers, captured request fields, read data and ready
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_pend   <= 1'b0;
         wr_pend   <= 1'b0;
         rd_addr   <= '0;
         wr_addr   <= '0;
         wr_data_q <= '0;
         rd_data   <= '0;
         ready     <= 1'b1;
      end else begin
         // NOTE: state uses non-blocking assignments so every register sees pre-edge values.
         rd_pend <= rd_pend_n;
         wr_pend <= wr_pend_n;
         // Falls on the edge that samples a pulse, rises once nothing is pending
         ready   <= ~(rd_pend_n | wr_pend_n);
         if (rd_take) rd_addr <= addr;
         if (wr_take) begin
            wr_addr   <= addr;
            wr_data_q <= wr_data;
         end
         if (rd_done) rd_data <= mem_rd_data;
      end
   end
endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU bus against a video DMA read port onto one single-port
// synchronous RAM, one outstanding access at a time.
// Build option: CPU_MEM_ARB_RR_EN selects round-robin arbitration (last
// granted master loses ties); otherwise video has priority with a streak
// guard that lets a waiting CPU in after VID_STREAK video grants.
module cpu_mem_arbiter
   import clc_bus_pkg::*;
#(
   parameter int ADDR_W     = 16,
   parameter int DATA_W     = 8,
   parameter int RD_LATENCY = 1,
   parameter int VID_STREAK = 4
) (
   input logic             clk,
   input logic             reset_n,
   cpu_mem_arbiter_if.slave bus
);
   localparam lat_cnt_t LAT_LAST = lat_cnt_t'(clamp_rd_latency(RD_LATENCY) - 1);

   logic              rd_pend, wr_pend;
   logic [ADDR_W-1:0] rd_addr, wr_addr;
   logic [DATA_W-1:0] wr_data_q;
   logic              grant_rd, grant_wr, grant_vid, rd_done, vid_done;
   logic              cpu_pend, arb_en, pick_vid, pick_cpu;

   state_t   state, state_n;
   owner_t   owner, owner_n;
   logic     op_wr, op_wr_n;
   lat_cnt_t cnt, cnt_n;

`ifdef CPU_MEM_ARB_RR_EN
   owner_t last_grant, last_n;
`else
   localparam int             SW         = $clog2(VID_STREAK + 1);
   localparam logic [SW-1:0]  STREAK_MAX = SW'(VID_STREAK);
   logic [SW-1:0]             streak, streak_n;
`endif

   cpu_req_capture #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_capture (
      .clk         (clk),
      .reset_n     (reset_n),
      .addr        (bus.addr),
      .rd_req      (bus.rd_req),
      .wr_en       (bus.wr_en),
      .wr_data     (bus.wr_data),
      .rd_done     (rd_done),
      .wr_grant    (grant_wr),
      .mem_rd_data (bus.mem_rd_data),
      .rd_pend     (rd_pend),
      .rd_addr     (rd_addr),
      .wr_pend     (wr_pend),
      .wr_addr     (wr_addr),
      .wr_data_q   (wr_data_q),
      .rd_data     (bus.rd_data),
      .ready       (bus.ready)
   );

   // Arbitration and next-state logic of the access FSM
   always_comb begin
      state_n   = state;
      owner_n   = owner;
      op_wr_n   = op_wr;
      cnt_n     = cnt;
      grant_rd  = 1'b0;
      grant_wr  = 1'b0;
      grant_vid = 1'b0;
      rd_done   = 1'b0;
      vid_done  = 1'b0;
      cpu_pend  = rd_pend | wr_pend;
      // While vid_ack is shown the master still holds its old request; skip that cycle
      arb_en    = (state == ST_IDLE) & ~bus.vid_ack;
`ifdef CPU_MEM_ARB_RR_EN
      last_n    = last_grant;
      if (bus.vid_req && cpu_pend) pick_vid = arb_en & (last_grant != OWN_VID);
      else                         pick_vid = arb_en & bus.vid_req;
      pick_cpu  = arb_en & cpu_pend & ~pick_vid;
      if (pick_vid)      last_n = OWN_VID;
      else if (pick_cpu) last_n = OWN_CPU;
`else
      streak_n  = streak;
      pick_vid  = arb_en & bus.vid_req & ~(cpu_pend & (streak == STREAK_MAX));
      pick_cpu  = arb_en & cpu_pend & ~pick_vid;
      if (!cpu_pend || pick_cpu)                   streak_n = '0;
      else if (pick_vid && streak != STREAK_MAX)   streak_n = streak + 1'b1;
`endif

      case (state)
         ST_IDLE: begin
            if (pick_vid) begin
               grant_vid = 1'b1;
               state_n   = ST_ISSUE;
               owner_n   = OWN_VID;
               op_wr_n   = 1'b0;
            end else if (pick_cpu) begin
               // A pending write always goes before a pending read
               grant_wr  = wr_pend;
               grant_rd  = ~wr_pend;
               state_n   = ST_ISSUE;
               owner_n   = OWN_CPU;
               op_wr_n   = wr_pend;
            end
         end
         ST_ISSUE: begin
            cnt_n = '0;
            if (op_wr) begin
               state_n = ST_IDLE;
               owner_n = OWN_NONE;
            end else begin
               state_n = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (cnt == LAT_LAST) begin
               state_n  = ST_IDLE;
               owner_n  = OWN_NONE;
               vid_done = (owner == OWN_VID);
               rd_done  = (owner == OWN_CPU);
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // FSM state, RAM port registers and video return path
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state           <= ST_IDLE;
         owner           <= OWN_NONE;
         op_wr           <= 1'b0;
         cnt             <= '0;
`ifdef CPU_MEM_ARB_RR_EN
         last_grant      <= OWN_NONE;
`else
         streak          <= '0;
`endif
         bus.mem_addr    <= '0;
         bus.mem_wr_en   <= 1'b0;
         bus.mem_wr_data <= '0;
         bus.vid_ack     <= 1'b0;
         bus.vid_data    <= '0;
      end else begin
         state         <= state_n;
         owner         <= owner_n;
         op_wr         <= op_wr_n;
         cnt           <= cnt_n;
`ifdef CPU_MEM_ARB_RR_EN
         last_grant    <= last_n;
`else
         streak        <= streak_n;
`endif
         bus.mem_wr_en <= grant_wr;
         bus.vid_ack   <= vid_done;
         if (grant_vid) bus.mem_addr <= bus.vid_addr;
         if (grant_rd)  bus.mem_addr <= rd_addr;
         if (grant_wr) begin
            bus.mem_addr    <= wr_addr;
            bus.mem_wr_data <= wr_data_q;
         end
         if (vid_done) bus.vid_data <= bus.mem_rd_data;
      end
   end
endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed tests on a latency-1
// instance, mixed CPU/video traffic on a latency-3 instance.
module tb_cpu_mem_arbiter;
   localparam int AW = 16;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   cpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus1 ();
   cpu_mem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus3 ();

   cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(1), .VID_STREAK(4)) u_dut1 (
      .clk(clk), .reset_n(reset_n), .bus(bus1.slave));
   cpu_mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LATENCY(3), .VID_STREAK(4)) u_dut3 (
      .clk(clk), .reset_n(reset_n), .bus(bus3.slave));

   logic [7:0] ram1 [0:65535];
   logic [7:0] ram3 [0:65535];
   logic [7:0] ref3 [0:65535];
   logic [7:0] pipe1;
   logic [7:0] pipe3 [0:2];
   int wr_cnt1 = 0;
   int vack_cnt3 = 0;
   int n_checks = 0;
   int n_fail = 0;

   function automatic logic [7:0] f_init(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'h5D;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Synchronous RAM models: latency 1 and latency 3
   always @(posedge clk) begin
      if (bus1.mem_wr_en) begin
         ram1[bus1.mem_addr] <= bus1.mem_wr_data;
         wr_cnt1 <= wr_cnt1 + 1;
      end
      pipe1 <= ram1[bus1.mem_addr];
      if (bus3.mem_wr_en) ram3[bus3.mem_addr] <= bus3.mem_wr_data;
      pipe3[0] <= ram3[bus3.mem_addr];
      pipe3[1] <= pipe3[0];
      pipe3[2] <= pipe3[1];
      if (bus3.vid_ack) vack_cnt3 <= vack_cnt3 + 1;
   end
   assign bus1.mem_rd_data = pipe1;
   assign bus3.mem_rd_data = pipe3[2];

   // One-cycle CPU pulse on bus1; returns at the negedge after the sampling edge
   task automatic pulse1(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bus1.addr = a; bus1.rd_req = rd; bus1.wr_en = wr; bus1.wr_data = d;
      @(negedge clk);
      bus1.rd_req = 1'b0; bus1.wr_en = 1'b0;
   endtask

   // Cycles (counted from the sampling edge) until ready is seen high, bounded
   task automatic wait_ready1(input string tag, output int k);
      k = 0;
      while (!bus1.ready && k < 200) begin
         @(negedge clk);
         k++;
      end
      check(tag, bus1.ready, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int k, w0, acks;
      logic [7:0] vd;
      bus1.addr = '0; bus1.rd_req = 1'b0; bus1.wr_en = 1'b0; bus1.wr_data = '0;
      bus1.vid_req = 1'b0; bus1.vid_addr = '0;
      bus3.addr = '0; bus3.rd_req = 1'b0; bus3.wr_en = 1'b0; bus3.wr_data = '0;
      bus3.vid_req = 1'b0; bus3.vid_addr = '0;
      for (int i = 0; i < 65536; i++) begin
         ram1[i] = f_init(16'(i));
         ram3[i] = f_init(16'(i));
         ref3[i] = f_init(16'(i));
      end
      ram1[16'h0444] = 8'hA9;
      ram1[16'hFFFC] = 8'hC3;

      // Reset values
      repeat (3) @(negedge clk);
      check("rst_ready",       bus1.ready, 1);
      check("rst_rd_data",     bus1.rd_data, 0);
      check("rst_vid_ack",     bus1.vid_ack, 0);
      check("rst_vid_data",    bus1.vid_data, 0);
      check("rst_mem_wr_en",   bus1.mem_wr_en, 0);
      check("rst_mem_addr",    bus1.mem_addr, 0);
      check("rst_mem_wr_data", bus1.mem_wr_data, 0);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Uncontended read: ready low next cycle, high RD_LATENCY+2 after sample
      pulse1(1'b1, 1'b0, 16'h0444, 8'h00);
      check("t1_ready_low", bus1.ready, 0);
      wait_ready1("t1_ready", k);
      check("t1_latency", k, 3);
      check("t1_rd_data", bus1.rd_data, 8'hA9);

      // Write then read two cycles later
      w0 = wr_cnt1;
      pulse1(1'b0, 1'b1, 16'h0080, 8'h5A);
      pulse1(1'b1, 1'b0, 16'h0080, 8'h00);
      wait_ready1("t2_ready", k);
      check("t2_rd_data", bus1.rd_data, 8'h5A);
      check("t2_wr_strobes", wr_cnt1 - w0, 1);

      // Read and write in the same cycle: write goes first
      pulse1(1'b1, 1'b1, 16'h0100, 8'h77);
      wait_ready1("t3_ready", k);
      check("t3_rd_data", bus1.rd_data, 8'h77);

      // Second read while one is pending is dropped
      pulse1(1'b1, 1'b0, 16'h0444, 8'h00);
      bus1.addr = 16'h0080; bus1.rd_req = 1'b1;
      @(negedge clk);
      bus1.rd_req = 1'b0;
      wait_ready1("t4_ready", k);
      check("t4_rd_data", bus1.rd_data, 8'hA9);
      repeat (4) @(negedge clk);
      check("t4_ready_held", bus1.ready, 1);
      check("t4_rd_data_held", bus1.rd_data, 8'hA9);

`ifndef CPU_MEM_ARB_RR_EN
      // Continuous video: CPU gets in after exactly VID_STREAK video acks
      acks = 0; vd = '0;
      @(negedge clk);
      bus1.addr = 16'h0444; bus1.rd_req = 1'b1;
      @(negedge clk);
      bus1.rd_req = 1'b0; bus1.vid_addr = 16'h9000; bus1.vid_req = 1'b1;
      k = 0;
      while (!bus1.ready && k < 300) begin
         @(negedge clk);
         k++;
         if (bus1.vid_ack) begin
            acks++;
            vd = bus1.vid_data;
         end
      end
      bus1.vid_req = 1'b0;
      check("t5_ready", bus1.ready, 1);
      check("t5_vid_acks", acks, 4);
      check("t5_vid_data", vd, f_init(16'h9000));
      check("t5_rd_data", bus1.rd_data, 8'hA9);
      repeat (6) @(negedge clk);
`else
      // Round-robin: each CPU read is preceded by exactly one video grant
      bus1.vid_addr = 16'h9000;
      for (int r = 0; r < 3; r++) begin
         acks = 0;
         @(negedge clk);
         bus1.addr = 16'h0444; bus1.rd_req = 1'b1;
         @(negedge clk);
         bus1.rd_req = 1'b0; bus1.vid_req = 1'b1;
         if (bus1.vid_ack) acks++;
         k = 0;
         while (!bus1.ready && k < 300) begin
            @(negedge clk);
            k++;
            if (bus1.vid_ack) acks++;
         end
         check("t5_rr_ready", bus1.ready, 1);
         check("t5_rr_acks", acks, 1);
      end
      bus1.vid_req = 1'b0;
      repeat (10) @(negedge clk);
`endif

      // Reset during WAIT with a write pending: aborted, no write afterwards
      w0 = wr_cnt1;
      pulse1(1'b1, 1'b0, 16'h0444, 8'h00);
      bus1.addr = 16'h0200; bus1.wr_data = 8'hEE; bus1.wr_en = 1'b1;
      @(negedge clk);
      bus1.wr_en = 1'b0;
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("t6_ready", bus1.ready, 1);
      check("t6_vid_ack", bus1.vid_ack, 0);
      check("t6_mem_wr_en", bus1.mem_wr_en, 0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      check("t6_no_write", wr_cnt1 - w0, 0);
      pulse1(1'b1, 1'b0, 16'hFFFC, 8'h00);
      wait_ready1("t6_post_ready", k);
      check("t6_post_rd_data", bus1.rd_data, 8'hC3);

      // Mixed CPU/video traffic on the latency-3 instance
      fork
         begin
            int kc;
            logic [15:0] a;
            logic [7:0] d;
            logic op;
            for (int i = 0; i < 40; i++) begin
               a  = 16'($urandom_range(0, 15));
               d  = 8'($urandom);
               op = 1'($urandom_range(0, 1));
               @(negedge clk);
               bus3.addr = a;
               if (op) begin
                  bus3.wr_en = 1'b1; bus3.wr_data = d; ref3[a] = d;
               end else begin
                  bus3.rd_req = 1'b1;
               end
               @(negedge clk);
               bus3.rd_req = 1'b0; bus3.wr_en = 1'b0;
               kc = 0;
               while (!bus3.ready && kc < 300) begin
                  @(negedge clk);
                  kc++;
               end
               check("r3_ready", bus3.ready, 1);
               if (!op) check("r3_rd_data", bus3.rd_data, ref3[a]);
            end
         end
         begin
            int kv;
            logic [15:0] va;
            for (int j = 0; j < 30; j++) begin
               va = 16'h8000 | 16'($urandom_range(0, 32767));
               @(negedge clk);
               bus3.vid_addr = va; bus3.vid_req = 1'b1;
               kv = 0;
               while (!bus3.vid_ack && kv < 300) begin
                  @(negedge clk);
                  kv++;
               end
               check("v3_ack", bus3.vid_ack, 1);
               check("v3_data", bus3.vid_data, f_init(va));
               bus3.vid_req = 1'b0;
            end
         end
      join
      repeat (10) @(negedge clk);
      check("v3_ack_total", vack_cnt3, 30);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
